// File: rtl/full_adder_pkg.sv
// Shared constants for the registered ripple-carry adder.
package full_adder_pkg;
    localparam int FA_MAX_WIDTH     = 64;
    localparam int FA_DEFAULT_WIDTH = 1;
endpackage

// File: rtl/full_adder_core_fa_cell.sv
// One-bit combinational full adder, the repeated cell of the ripple chain.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/full_adder_core.sv
// Registered WIDTH-bit ripple-carry adder: {cout, sum} <= a + b + cin, one cycle latency.
// Define FULL_ADDER_OVF_EN to add the registered two's-complement overflow output ovf.
module full_adder_core
    import full_adder_pkg::*;
#(
    parameter int WIDTH = FA_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef FULL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    if (WIDTH < 1 || WIDTH > FA_MAX_WIDTH) begin : g_bad_width
        $error("full_adder_core: WIDTH out of range");
    end

    logic [WIDTH-1:0] chain_sum;
    logic             carry_out;
    logic             carry_msb_in;

    // Each stage owns its carry so the chain is a plain bit-to-bit ripple.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic ci;
        logic co;
        if (i == 0) begin : g_first
            assign ci = cin;
        end else begin : g_next
            assign ci = g_bit[i-1].co;
        end
        fa_cell u_cell (
            .a   (a[i]),
            .b   (b[i]),
            .cin (ci),
            .sum (chain_sum[i]),
            .cout(co)
        );
    end

    assign carry_out    = g_bit[WIDTH-1].co;
    assign carry_msb_in = g_bit[WIDTH-1].ci;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                sum  <= chain_sum;
                cout <= carry_out;
            end
        end
    end

`ifdef FULL_ADDER_OVF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (in_valid) begin
            ovf <= carry_out ^ carry_msb_in;
        end
    end
`else
    logic unused_carry_msb_in;
    assign unused_carry_msb_in = carry_msb_in;
`endif

endmodule

// File: tb/tb_full_adder_core.sv
// Bench for full_adder_core at WIDTH = 1 and WIDTH = 8 sharing clock, reset and valid.
module tb_full_adder_core;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       in_valid = 1'b0;
    logic       cin = 1'b0;
    logic [0:0] a1 = '0;
    logic [0:0] b1 = '0;
    logic [7:0] a8 = '0;
    logic [7:0] b8 = '0;

    logic       out_valid1, cout1, out_valid8, cout8;
    logic [0:0] sum1;
    logic [7:0] sum8;
`ifdef FULL_ADDER_OVF_EN
    logic       ovf1, ovf8;
`endif

    int errors = 0;
    int checks = 0;

    full_adder_core #(.WIDTH(1)) u_w1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .a        (a1),
        .b        (b1),
        .cin      (cin),
        .out_valid(out_valid1),
        .sum      (sum1),
        .cout     (cout1)
`ifdef FULL_ADDER_OVF_EN
        ,
        .ovf      (ovf1)
`endif
    );

    full_adder_core #(.WIDTH(8)) u_w8 (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .a        (a8),
        .b        (b8),
        .cin      (cin),
        .out_valid(out_valid8),
        .sum      (sum8),
        .cout     (cout8)
`ifdef FULL_ADDER_OVF_EN
        ,
        .ovf      (ovf8)
`endif
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // ---------------- reference model ----------------
    function automatic logic [8:0] ref_add8(input logic [7:0] x, input logic [7:0] y, input logic c);
        int total;
        total = int'(x) + int'(y) + int'(c);
        return total[8:0];
    endfunction

    function automatic logic [1:0] ref_add1(input logic x, input logic y, input logic c);
        int total;
        total = int'(x) + int'(y) + int'(c);
        return total[1:0];
    endfunction

    // Signed overflow: the true signed sum falls outside the WIDTH-bit range.
    function automatic logic ref_ovf(input int w, input int x, input int y, input logic c);
        int sx, sy, total, lim;
        lim   = 1 << (w - 1);
        sx    = (x >= lim) ? x - 2 * lim : x;
        sy    = (y >= lim) ? y - 2 * lim : y;
        total = sx + sy + int'(c);
        return (total >= lim) || (total < -lim);
    endfunction

    // Scoreboard entry: {cout1, sum1, cout8, sum8}
    logic [10:0] exp_q[$];
`ifdef FULL_ADDER_OVF_EN
    logic [1:0]  exp_ovf_q[$];
`endif

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic randomize_operands();
        a1  = 1'($urandom_range(0, 1));
        b1  = 1'($urandom_range(0, 1));
        a8  = 8'($urandom_range(0, 255));
        b8  = 8'($urandom_range(0, 255));
        cin = 1'($urandom_range(0, 1));
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        in_valid = 1'b1;
        a1 = 1'b1; b1 = 1'b1; cin = 1'b1;
        a8 = 8'hFF; b8 = 8'hFF;
        step();
        step();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid8, cout8, sum8} !== 10'h000) begin
            errors++;
            $display("FAIL reset_async_w8: got ov=%b cout=%b sum=%h want 0/0/00", out_valid8, cout8, sum8);
        end
        checks++;
        if ({out_valid1, cout1, sum1} !== 3'b000) begin
            errors++;
            $display("FAIL reset_async_w1: got ov=%b cout=%b sum=%b want 0/0/0", out_valid1, cout1, sum1);
        end
`ifdef FULL_ADDER_OVF_EN
        checks++;
        if ({ovf1, ovf8} !== 2'b00) begin
            errors++;
            $display("FAIL reset_async_ovf: got %b%b want 00", ovf1, ovf8);
        end
`endif
        for (int i = 0; i < 3; i++) begin
            randomize_operands();
            in_valid = 1'b1;
            step();
            checks++;
            if ({out_valid8, cout8, sum8, out_valid1, cout1, sum1} !== 13'h0) begin
                errors++;
                $display("FAIL reset_hold[%0d]: got w8 %b/%b/%h w1 %b/%b/%b want all 0",
                         i, out_valid8, cout8, sum8, out_valid1, cout1, sum1);
            end
        end
        in_valid = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_truth_table();
        logic [1:0] exp;
        for (int i = 0; i < 8; i++) begin
            {a1, b1, cin} = 3'(i);
            a8 = 8'($urandom_range(0, 255));
            b8 = 8'($urandom_range(0, 255));
            in_valid = 1'b1;
            exp = ref_add1(a1[0], b1[0], cin);
            step();
            checks++;
            if ({out_valid1, cout1, sum1} !== {1'b1, exp}) begin
                errors++;
                $display("FAIL truth_table[%0d]: got ov=%b cout=%b sum=%b want 1/%b/%b",
                         i, out_valid1, cout1, sum1, exp[1], exp[0]);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_gap();
        a1 = 1'b1; b1 = 1'b1; cin = 1'b0; in_valid = 1'b1;
        step();
        checks++;
        if ({out_valid1, sum1, cout1} !== 3'b101) begin
            errors++;
            $display("FAIL gap_valid: got ov=%b sum=%b cout=%b want 1/0/1", out_valid1, sum1, cout1);
        end
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b0;
            a1 = 1'b0; b1 = 1'b0; cin = 1'b1;
            step();
            checks++;
            if ({out_valid1, sum1, cout1} !== 3'b001) begin
                errors++;
                $display("FAIL gap_idle[%0d]: got ov=%b sum=%b cout=%b want 0/0/1", i, out_valid1, sum1, cout1);
            end
        end
    endtask

    task automatic test_wrap8();
        a8 = 8'hFF; b8 = 8'hFF; cin = 1'b1; in_valid = 1'b1;
        step();
        checks++;
        if ({out_valid8, cout8, sum8} !== {1'b1, 1'b1, 8'hFF}) begin
            errors++;
            $display("FAIL wrap_ones: got ov=%b cout=%b sum=%h want 1/1/ff", out_valid8, cout8, sum8);
        end
        a8 = 8'h00; b8 = 8'h01; cin = 1'b0;
        step();
        checks++;
        if ({out_valid8, cout8, sum8} !== {1'b1, 1'b0, 8'h01}) begin
            errors++;
            $display("FAIL wrap_small: got ov=%b cout=%b sum=%h want 1/0/01", out_valid8, cout8, sum8);
        end
        a8 = 8'h00; b8 = 8'h00; cin = 1'b0;
        step();
        checks++;
        if ({out_valid8, cout8, sum8} !== {1'b1, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL wrap_zero: got ov=%b cout=%b sum=%h want 1/0/00", out_valid8, cout8, sum8);
        end
        in_valid = 1'b0;
    endtask

`ifdef FULL_ADDER_OVF_EN
    task automatic test_ovf();
        a8 = 8'h7F; b8 = 8'h01; cin = 1'b0; in_valid = 1'b1;
        step();
        checks++;
        if ({ovf8, cout8, sum8} !== {1'b1, 1'b0, 8'h80}) begin
            errors++;
            $display("FAIL ovf_pos: got ovf=%b cout=%b sum=%h want 1/0/80", ovf8, cout8, sum8);
        end
        a8 = 8'h80; b8 = 8'h80;
        step();
        checks++;
        if ({ovf8, cout8, sum8} !== {1'b1, 1'b1, 8'h00}) begin
            errors++;
            $display("FAIL ovf_neg: got ovf=%b cout=%b sum=%h want 1/1/00", ovf8, cout8, sum8);
        end
        in_valid = 1'b0;
    endtask
`endif

    task automatic test_back_to_back();
        logic [10:0] exp, last;
        logic [8:0]  r8;
        logic [1:0]  r1;
        logic        v;
`ifdef FULL_ADDER_OVF_EN
        logic [1:0]  exp_ovf, last_ovf;
        last_ovf = {ovf1, ovf8};
`endif
        // Seed the hold value from a known transaction first.
        a1 = 1'b0; b1 = 1'b1; cin = 1'b0; a8 = 8'h3C; b8 = 8'h0F; in_valid = 1'b1;
        last = {2'b01, 1'b0, 8'h4B};
        step();
`ifdef FULL_ADDER_OVF_EN
        last_ovf = {ref_ovf(1, 0, 1, 1'b0), ref_ovf(8, 'h3C, 'h0F, 1'b0)};
`endif
        for (int i = 0; i < 300; i++) begin
            randomize_operands();
            v = ($urandom_range(0, 3) != 0);
            in_valid = v;
            if (v) begin
                r8 = ref_add8(a8, b8, cin);
                r1 = ref_add1(a1[0], b1[0], cin);
                exp_q.push_back({r1, r8});
`ifdef FULL_ADDER_OVF_EN
                exp_ovf_q.push_back({ref_ovf(1, int'(a1), int'(b1), cin), ref_ovf(8, int'(a8), int'(b8), cin)});
`endif
            end
            step();
            checks++;
            if ({out_valid1, out_valid8} !== {v, v}) begin
                errors++;
                $display("FAIL stream_valid[%0d]: got %b%b want %b%b", i, out_valid1, out_valid8, v, v);
            end
            if (v && exp_q.size() > 0) begin
                last = exp_q.pop_front();
`ifdef FULL_ADDER_OVF_EN
                last_ovf = exp_ovf_q.pop_front();
`endif
            end
            exp = last;
            checks++;
            if ({cout1, sum1, cout8, sum8} !== exp) begin
                errors++;
                $display("FAIL stream_data[%0d]: got w1 %b%b w8 %b/%h want w1 %b%b w8 %b/%h",
                         i, cout1, sum1, cout8, sum8, exp[10], exp[9], exp[8], exp[7:0]);
            end
`ifdef FULL_ADDER_OVF_EN
            exp_ovf = last_ovf;
            checks++;
            if ({ovf1, ovf8} !== exp_ovf) begin
                errors++;
                $display("FAIL stream_ovf[%0d]: got %b%b want %b", i, ovf1, ovf8, exp_ovf);
            end
`endif
        end
        in_valid = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL stream_drain: %0d results never emerged, want 0", exp_q.size());
        end
    endtask

    task automatic test_reset_midstream();
        a8 = 8'h12; b8 = 8'h34; cin = 1'b0; in_valid = 1'b1;
        step();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid8, cout8, sum8} !== 10'h000) begin
            errors++;
            $display("FAIL midstream_discard: got ov=%b cout=%b sum=%h want 0/0/00", out_valid8, cout8, sum8);
        end
        // Valid input held across an edge while reset is low must never surface.
        a8 = 8'h55; b8 = 8'h22; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        rst_n = 1'b1;
        step();
        checks++;
        if ({out_valid8, cout8, sum8, out_valid1} !== 11'h000) begin
            errors++;
            $display("FAIL midstream_no_output: got ov8=%b cout=%b sum=%h ov1=%b want 0/0/00/0",
                     out_valid8, cout8, sum8, out_valid1);
        end
        a8 = 8'h01; b8 = 8'h02; cin = 1'b1; in_valid = 1'b1;
        step();
        checks++;
        if ({out_valid8, cout8, sum8} !== {1'b1, 1'b0, 8'h04}) begin
            errors++;
            $display("FAIL midstream_recover: got ov=%b cout=%b sum=%h want 1/0/04", out_valid8, cout8, sum8);
        end
        in_valid = 1'b0;
    endtask

    initial begin
        #2;
        test_reset();
        test_truth_table();
        test_gap();
        test_wrap8();
`ifdef FULL_ADDER_OVF_EN
        test_ovf();
`endif
        test_back_to_back();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
